// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register map, reset defaults and
// synchroniser depth floor.
package gpio_bank_pkg;

    // Register indices on the 3-bit register port address.
    localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
    localparam logic [2:0] ADDR_OEB        = 3'd1;
    localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
    localparam logic [2:0] ADDR_IRQ_RISE   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_FALL   = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
    localparam logic [2:0] ADDR_DEBOUNCE   = 3'd6;
    localparam logic [2:0] ADDR_TOGGLE     = 3'd7;

    // DEBOUNCE_LIMIT value after reset.
    localparam int unsigned DEBOUNCE_LIMIT_RESET = 4;

    // Fewer synchroniser flops than this is not metastability-safe.
    localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/gpio_debounce.sv
// One pin's input path: synchroniser chain, saturating debounce counter,
// debounced stable value and single-cycle rise/fall event strobes.
module gpio_debounce
    import gpio_bank_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pad,
    input  logic [DEBOUNCE_W-1:0] limit,
    output logic                  stable,
    output logic                  rise,
    output logic                  fall
);

    localparam int unsigned STAGES =
        (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0]     sync_q;
    logic                  sync;
    logic [DEBOUNCE_W-1:0] cnt;
    logic [DEBOUNCE_W-1:0] lim_m1;
    logic                  differ;
    logic                  settle;

    assign sync = sync_q[STAGES-1];

    // Shift the raw pad value through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pad};
        end
    end

    // Settle condition; a limit of 0 behaves like 1.  rise/fall are
    // combinational so the owner can latch the event on the same edge that
    // updates stable.
    always_comb begin
        lim_m1 = (limit == '0) ? '0 : (limit - DEBOUNCE_W'(1));
        differ = (sync != stable);
        settle = differ && (cnt >= lim_m1);
        rise   = settle && sync;
        fall   = settle && !sync;
    end

    // Count consecutive disagreeing cycles; accept the new level at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (settle) begin
            stable <= sync;
            cnt    <= '0;
        end else if (differ) begin
            if (cnt != '1) begin
                cnt <= cnt + DEBOUNCE_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: per-pin output/direction registers, debounced inputs with
// edge interrupts, controlled through a valid/ready register port.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned NUM_IO      = 24,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    input  logic              reg_valid,
    output logic              reg_ready,
    input  logic              reg_write,
    input  logic [2:0]        reg_addr,
    input  logic [NUM_IO-1:0] reg_wdata,
    output logic              rd_valid,
    output logic [NUM_IO-1:0] rd_data,
    output logic              irq
);

    logic [NUM_IO-1:0]     data_out;
    logic [NUM_IO-1:0]     oeb;
    logic [NUM_IO-1:0]     data_in;
    logic [NUM_IO-1:0]     rise_en;
    logic [NUM_IO-1:0]     fall_en;
    logic [NUM_IO-1:0]     irq_status;
    logic [DEBOUNCE_W-1:0] debounce_limit;
    logic [NUM_IO-1:0]     rise;
    logic [NUM_IO-1:0]     fall;

    logic                  accept;
    logic                  do_write;
    logic [NUM_IO-1:0]     rd_mux;
    logic [NUM_IO-1:0]     status_set;
    logic [NUM_IO-1:0]     status_clr;

    for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .pad    (io_in[i]),
            .limit  (debounce_limit),
            .stable (data_in[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

    assign io_out = data_out;
    assign io_oeb = oeb;
    assign irq    = |irq_status;

    // Handshake decode, read mux and interrupt set/clear vectors.
    always_comb begin
        accept     = reg_valid && reg_ready;
        do_write   = accept && reg_write;
        status_set = (rise & rise_en) | (fall & fall_en);
        status_clr = (do_write && reg_addr == ADDR_IRQ_STATUS) ? reg_wdata : '0;
        rd_mux     = '0;
        case (reg_addr)
            ADDR_DATA_OUT:   rd_mux = data_out;
            ADDR_OEB:        rd_mux = oeb;
            ADDR_DATA_IN:    rd_mux = data_in;
            ADDR_IRQ_RISE:   rd_mux = rise_en;
            ADDR_IRQ_FALL:   rd_mux = fall_en;
            ADDR_IRQ_STATUS: rd_mux = irq_status;
            ADDR_DEBOUNCE:   rd_mux = NUM_IO'(debounce_limit);
            default:         rd_mux = '0;
        endcase
    end

    // Port becomes ready one edge after reset release and stays ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ready <= 1'b0;
        end else begin
            reg_ready <= 1'b1;
        end
    end

    // Capture read data on the accepting edge; valid for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= accept && !reg_write;
            if (accept && !reg_write) begin
                rd_data <= rd_mux;
            end
        end
    end

    // Writable control registers; DATA_IN and IRQ_STATUS are handled elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            oeb            <= '1;
            rise_en        <= '0;
            fall_en        <= '0;
            debounce_limit <= DEBOUNCE_W'(DEBOUNCE_LIMIT_RESET);
        end else if (do_write) begin
            case (reg_addr)
                ADDR_DATA_OUT: data_out       <= reg_wdata;
                ADDR_OEB:      oeb            <= reg_wdata;
                ADDR_IRQ_RISE: rise_en        <= reg_wdata;
                ADDR_IRQ_FALL: fall_en        <= reg_wdata;
                ADDR_DEBOUNCE: debounce_limit <= DEBOUNCE_W'(reg_wdata);
                ADDR_TOGGLE:   data_out       <= data_out ^ reg_wdata;
                default:       ;
            endcase
        end
    end

    // Sticky interrupt status; a same-cycle set overrides the W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~status_clr) | status_set;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: register vector table plus hand-written
// debounce, interrupt, collision and async-reset sequences.
module tb_gpio_bank;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_OEB = 2;

    typedef struct {
        bit        wr;
        bit [2:0]  addr;
        bit [23:0] wdata;
        int        kind;
        bit [23:0] exp;
        string     name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [23:0] io_in;
    logic [23:0] io_out;
    logic [23:0] io_oeb;
    logic        reg_valid;
    logic        reg_ready;
    logic        reg_write;
    logic [2:0]  reg_addr;
    logic [23:0] reg_wdata;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        irq;

    int n_pass = 0;
    int n_total = 0;
    vec_t vecs[$];

    gpio_bank #(
        .NUM_IO      (24),
        .SYNC_STAGES (2),
        .DEBOUNCE_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .reg_valid (reg_valid),
        .reg_ready (reg_ready),
        .reg_write (reg_write),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        reg_valid = 1'b1;
        reg_write = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_valid = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [23:0] d, output logic v);
        reg_valid = 1'b1;
        reg_write = 1'b0;
        reg_addr  = a;
        tick();
        reg_valid = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic add(input bit w, input bit [2:0] a, input bit [23:0] d,
                       input int k, input bit [23:0] e, input string n);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.kind = k; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic [23:0] d;
        logic        v;

        rst_n     = 1'b0;
        io_in     = '0;
        reg_valid = 1'b0;
        reg_write = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;

        add(1, 3'd1, 24'hFFFF00, K_OEB, 24'hFFFF00, "oeb_wr");
        add(1, 3'd0, 24'h0000A5, K_OUT, 24'h0000A5, "dout_wr");
        add(1, 3'd7, 24'h0000FF, K_OUT, 24'h00005A, "toggle_wr");
        add(0, 3'd0, 24'h0,      K_RD,  24'h00005A, "dout_rd");
        add(0, 3'd1, 24'h0,      K_RD,  24'hFFFF00, "oeb_rd");
        add(0, 3'd7, 24'h0,      K_RD,  24'h000000, "toggle_rd");
        add(1, 3'd2, 24'h123456, K_OUT, 24'h00005A, "din_wr_ignored");
        add(0, 3'd2, 24'h0,      K_RD,  24'h000000, "din_rd");
        add(1, 3'd3, 24'hABCDEF, K_OUT, 24'h00005A, "rise_en_wr");
        add(0, 3'd3, 24'h0,      K_RD,  24'hABCDEF, "rise_en_rd");
        add(1, 3'd4, 24'h123456, K_OEB, 24'hFFFF00, "fall_en_wr");
        add(0, 3'd4, 24'h0,      K_RD,  24'h123456, "fall_en_rd");
        add(1, 3'd6, 24'hFFFF03, K_OUT, 24'h00005A, "limit_wr");
        add(0, 3'd6, 24'h0,      K_RD,  24'h000003, "limit_rd_trunc");
        add(1, 3'd7, 24'h800001, K_OUT, 24'h80005B, "toggle2_wr");
        add(1, 3'd3, 24'h000000, K_OUT, 24'h80005B, "rise_en_clr");
        add(1, 3'd4, 24'h000000, K_OUT, 24'h80005B, "fall_en_clr");
        add(1, 3'd6, 24'h000004, K_OUT, 24'h80005B, "limit_restore");
        add(0, 3'd5, 24'h0,      K_RD,  24'h000000, "status_rd");

        // Reset held with clock running
        repeat (3) tick();
        chk("rst_oeb", io_oeb, 24'hFFFFFF);
        chk("rst_out", io_out, 24'h0);
        chk("rst_ready", reg_ready, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_rdvalid", rd_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", reg_ready, 1'b0);
        tick();
        chk("ready_after_edge", reg_ready, 1'b1);
        rd(3'd6, d, v);
        chk("limit_reset_valid", v, 1'b1);
        chk("limit_reset_val", d, 24'd4);
        tick();
        chk("rdvalid_one_cycle", rd_valid, 1'b0);

        // Register vector table
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
                chk({vecs[i].name, "_novalid"}, rd_valid, 1'b0);
                if (vecs[i].kind == K_OEB) chk(vecs[i].name, io_oeb, vecs[i].exp);
                else                       chk(vecs[i].name, io_out, vecs[i].exp);
            end else begin
                rd(vecs[i].addr, d, v);
                chk({vecs[i].name, "_valid"}, v, 1'b1);
                chk(vecs[i].name, d, vecs[i].exp);
            end
        end

        // Back-to-back write then read with valid held high
        reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 3'd0; reg_wdata = 24'h00003C;
        tick();
        chk("b2b_wr_out", io_out, 24'h00003C);
        reg_write = 1'b0;
        tick();
        reg_valid = 1'b0;
        chk("b2b_rd_valid", rd_valid, 1'b1);
        chk("b2b_rd_data", rd_data, 24'h00003C);

        // Debounce, L=4: 3-cycle glitch on pin 3 never reaches DATA_IN
        tick();
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 3'd2;
        io_in[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) io_in[3] = 1'b0;
            chk($sformatf("glitch_din_%0d", k), rd_data[3], 1'b0);
        end
        // Held high: DATA_IN[3] updates on edge 6, visible via the read at edge 7
        io_in[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("hold_din_%0d", k), rd_data[3], (k >= 7) ? 1'b1 : 1'b0);
        end
        reg_valid = 1'b0;
        io_in[3] = 1'b0;
        repeat (8) tick();
        rd(3'd2, d, v);
        chk("din_back_low", d, 24'h0);

        // Rise interrupt on pin 5 with L=1
        wr(3'd3, 24'h000020);
        wr(3'd6, 24'h000001);
        io_in[5] = 1'b1;
        tick(); tick();
        chk("rise_irq_early", irq, 1'b0);
        tick();
        chk("rise_irq_set", irq, 1'b1);
        rd(3'd5, d, v);
        chk("rise_status", d, 24'h000020);
        // Falling edge with FALL_EN=0 adds nothing
        io_in[5] = 1'b0;
        repeat (5) tick();
        rd(3'd5, d, v);
        chk("fall_disabled_status", d, 24'h000020);
        wr(3'd5, 24'h000020);
        chk("w1c_irq_clear", irq, 1'b0);
        rd(3'd5, d, v);
        chk("w1c_status", d, 24'h0);

        // W1C on the same edge as a new rise: set wins
        io_in[5] = 1'b1;
        tick(); tick();
        wr(3'd5, 24'h000020);
        chk("collide_irq", irq, 1'b1);
        rd(3'd5, d, v);
        chk("collide_status", d, 24'h000020);
        wr(3'd5, 24'h000020);
        chk("collide_then_clear", irq, 1'b0);

        // Fall interrupt
        wr(3'd4, 24'h000020);
        io_in[5] = 1'b0;
        tick(); tick();
        chk("fall_irq_early", irq, 1'b0);
        tick();
        chk("fall_irq_set", irq, 1'b1);

        // Async reset during a debounce count with a read pending
        wr(3'd6, 24'h000009);
        io_in[7] = 1'b1;
        repeat (3) tick();
        reg_valid = 1'b1; reg_write = 1'b0; reg_addr = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", io_out, 24'h0);
        chk("arst_oeb", io_oeb, 24'hFFFFFF);
        chk("arst_ready", reg_ready, 1'b0);
        chk("arst_rdvalid", rd_valid, 1'b0);
        chk("arst_rddata", rd_data, 24'h0);
        chk("arst_irq", irq, 1'b0);
        reg_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("post_rst_rdvalid_%0d", k), rd_valid, 1'b0);
        end
        rd(3'd6, d, v);
        chk("post_rst_limit", d, 24'd4);
        rd(3'd5, d, v);
        chk("post_rst_status", d, 24'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
Parametrised GPIO controller instantiated inside the user design `top`, driving the fabric's bidirectional IO BELs through `io_in`/`io_out`/`io_oeb`. Per-pin features:
- direction and output registers;
- input synchronisation and counter-based debounce;
- rise/fall edge interrupts.

A simple valid/ready register port lets on-fabric logic (soft CPU, UART bridge) control the bank. This generalises the fixed 24-pin passthrough to any pin count, with registered, filtered behaviour.

Parameters:
- NUM_IO, 24, pin count; also the data width of the register port (1..32).
- SYNC_STAGES, 2, input synchroniser flops per pin (>=2).
- DEBOUNCE_W, 8, width of the per-pin debounce counter and of the DEBOUNCE_LIMIT register.

Ports:
- clk  in  1  fabric global clock.
- rst_n  in  1  asynchronous active-low reset.
- io_in  in  NUM_IO  raw pad inputs from the IO BEL O pins.
- io_out  out  NUM_IO  pad output data to the IO BEL I pins.
- io_oeb  out  NUM_IO  output-enable-bar to the IO BEL T pins; 1 = pad is an input.
- reg_valid  in  1  register request valid.
- reg_ready  out  1  register port ready.
- reg_write  in  1  1 = write, 0 = read.
- reg_addr  in  3  register index.
- reg_wdata  in  NUM_IO  write data.
- rd_valid  out  1  one-cycle pulse, read data valid.
- rd_data  out  NUM_IO  read data.
- irq  out  1  level interrupt; OR of IRQ_STATUS.

Behaviour:
- Reset is asynchronous on rst_n low:
  - io_out=0, io_oeb=all 1s, rd_valid=0, rd_data=0, irq=0, reg_ready=0;
  - all registers, synchronisers, debounce counters and stable values = 0;
  - DEBOUNCE_LIMIT = 4.
  - reg_ready rises on the first clk edge after rst_n deasserts and then stays 1.
- A transfer is accepted on a clk edge with reg_valid && reg_ready. Writes take effect at that edge. A read returns rd_data with rd_valid=1 on the following cycle. Back-to-back transfers are allowed every cycle.
- Register map (bits above NUM_IO ignored/read 0):
  - 0 DATA_OUT (RW): drives io_out.
  - 1 OEB (RW): drives io_oeb.
  - 2 DATA_IN (RO): debounced stable pin values; writes ignored.
  - 3 IRQ_RISE_EN (RW).
  - 4 IRQ_FALL_EN (RW).
  - 5 IRQ_STATUS: RW1C.
  - 6 DEBOUNCE_LIMIT (RW): low DEBOUNCE_W bits.
  - 7 TOGGLE (WO): DATA_OUT ^= wdata; reads 0.
- Synchroniser: SYNC_STAGES flops per pin, giving `sync[i]`.
- Debounce, per pin, per edge:
  - if sync != stable: when cnt >= L-1 (L = DEBOUNCE_LIMIT; L=0 treated as 1), then stable <= sync and cnt <= 0; else cnt++.
  - if sync == stable: cnt <= 0.
  - A glitch shorter than L cycles never changes stable.
  - cnt saturates; it never wraps.
- Latency from a clean pad change to a DATA_IN change = SYNC_STAGES + L cycles.
- Edge detect: on the edge where stable changes 0->1 (1->0), set IRQ_STATUS[i] if IRQ_RISE_EN[i] (IRQ_FALL_EN[i]).
- Simultaneous events:
  - a status set and a W1C clear of the same bit in the same cycle: set wins;
  - a DATA_OUT write and a TOGGLE cannot coincide (single port).
- irq = |IRQ_STATUS, taken from registers; asserts the cycle after the status bit is set.
- Direction: io_out is driven regardless of io_oeb. Pins with oeb=0 still feed the synchroniser, so readback of driven pins works.
- Reset mid-transfer aborts the transfer; no rd_valid is produced.

Decomposition:
- Package `gpio_bank_pkg`: register address localparams (ADDR_DATA_OUT..ADDR_TOGGLE), DEBOUNCE_LIMIT reset value 4, SYNC_STAGES minimum.
- Sub-module `gpio_debounce`: one pin's synchroniser, counter, stable flop and rise/fall pulses, parametrised by SYNC_STAGES and DEBOUNCE_W; instantiated NUM_IO times in a generate loop.

Test Plan:
- Reset/idle: hold rst_n=0 with clk running -> io_oeb=24'hFFFFFF, io_out=0, reg_ready=0. Release -> reg_ready=1 next edge. Read addr 6 -> rd_data=4 one cycle after accept.
- Output path: write OEB=24'hFFFF00 and DATA_OUT=24'h0000A5 -> io_out=24'h0000A5, io_oeb=24'hFFFF00 on the accepting edge. Write TOGGLE=24'h0000FF -> io_out=24'h00005A.
- Debounce: L=4. Pulse io_in[3] high for 3 cycles -> DATA_IN stays 0. Hold high 10 cycles -> DATA_IN[3]=1 exactly 2+4 cycles after the change.
- Edge IRQ: IRQ_RISE_EN=1<<5, L=1. Raise io_in[5] -> IRQ_STATUS=0x20 and irq=1. Falling edge with FALL_EN=0 -> no new bits. W1C 0x20 -> irq=0.
- Set/clear collision: time W1C of bit 5 on the same edge as a new rise on pin 5 -> bit 5 stays 1, irq stays 1.
- Async reset mid-operation: during active debounce count and pending read, pull rst_n low between edges -> all outputs at reset values immediately; no rd_valid pulse after release.
